// File: rtl/jk_mon_pkg.sv
// Shared types and helpers for the JK flip-flop checker (jk_ff_checker).
// Optional operation coverage counters are enabled with the JK_OP_COV_EN macro.
package jk_mon_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'd0,
    OP_SET  = 2'd1,
    OP_CLR  = 2'd2,
    OP_TOG  = 2'd3
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_UNKNOWN = 2'd0,
    ST_TRACK   = 2'd1,
    ST_FAIL    = 2'd2
  } chk_state_e;

  // Golden flip-flop value plus whether that value is trustworthy yet.
  typedef struct packed {
    logic q;
    logic known;
  } model_t;

  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 4;

  function automatic jk_op_e jk_decode(input logic j, input logic k);
    case ({j, k})
      2'b10:   return OP_SET;
      2'b01:   return OP_CLR;
      2'b11:   return OP_TOG;
      default: return OP_HOLD;
    endcase
  endfunction

  function automatic logic jk_next(input logic q, input jk_op_e op);
    case (op)
      OP_SET:  return 1'b1;
      OP_CLR:  return 1'b0;
      OP_TOG:  return ~q;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Golden JK flip-flop model driven from the monitored DUT pins.
// With JK_OP_COV_EN defined it also exports the decoded operation for coverage.
module jk_ref_model
  import jk_mon_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   j,
  input  logic   k,
  input  logic   en,
  input  logic   mon_rst,
  output model_t model
`ifdef JK_OP_COV_EN
  ,
  output jk_op_e op,
  output logic   op_en
`endif
);

  jk_op_e op_dec;

  assign op_dec = jk_decode(j, k);

  // NOTE: sequential state uses <= so every register sees pre-edge values,
  // independent of statement order inside the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      model <= '0;
    end else if (mon_rst) begin
      model <= '{q: 1'b0, known: 1'b1};
    end else if (en) begin
      model.q <= jk_next(model.q, op_dec);
      // A toggle of an unknown value stays unknown; only set/clear pin it down.
      if (op_dec == OP_SET || op_dec == OP_CLR) begin
        model.known <= 1'b1;
      end
    end
  end

`ifdef JK_OP_COV_EN
  assign op    = op_dec;
  assign op_en = en & ~mon_rst;
`endif

endmodule

// File: rtl/jk_ff_checker.sv
// Scoreboard for a clocked JK flip-flop: golden model, latency alignment, compare FSM, counters.
// Define JK_OP_COV_EN to add saturating per-operation coverage counters (cov_* outputs).
module jk_ff_checker
  import jk_mon_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int ERR_W   = 8,
  parameter int CHK_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_j,
  input  logic             mon_k,
  input  logic             mon_en,
  input  logic             mon_rst,
  input  logic             mon_q,
  input  logic             clr_err,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic [CHK_W-1:0] chk_count,
  output logic [1:0]       state
`ifdef JK_OP_COV_EN
  ,
  output logic [CHK_W-1:0] cov_hold,
  output logic [CHK_W-1:0] cov_set,
  output logic [CHK_W-1:0] cov_clr,
  output logic [CHK_W-1:0] cov_tog,
  output logic [CHK_W-1:0] cov_rst
`endif
);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("jk_ff_checker: LATENCY must be in 1..4");
  end

  model_t     model;
  model_t     exp_m;
  chk_state_e st;
  logic       cmp_en;
  logic       cmp_miss;

`ifdef JK_OP_COV_EN
  jk_op_e op;
  logic   op_en;
`endif

  jk_ref_model u_model (
    .clk     (clk),
    .rst     (rst),
    .j       (mon_j),
    .k       (mon_k),
    .en      (mon_en),
    .mon_rst (mon_rst),
    .model   (model)
`ifdef JK_OP_COV_EN
    ,
    .op      (op),
    .op_en   (op_en)
`endif
  );

  // The model register is the first latency stage; extra stages follow it.
  if (LATENCY <= 1) begin : g_no_dly
    assign exp_m = model;
  end else begin : g_dly
    model_t dly [LATENCY-1];

    // NOTE: this delay line is reset on purpose: stale known=1 entries would
    // trigger compares against history that a checker reset must discard.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LATENCY - 1; i++) begin
          dly[i] <= '0;
        end
      end else begin
        dly[0] <= model;
        for (int i = 1; i < LATENCY - 1; i++) begin
          dly[i] <= dly[i-1];
        end
      end
    end

    assign exp_m = dly[LATENCY-2];
  end

  assign cmp_en   = exp_m.known;
  assign cmp_miss = cmp_en && (mon_q != exp_m.q);

  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= ST_UNKNOWN;
      mismatch  <= 1'b0;
      err_count <= '0;
      chk_count <= '0;
    end else begin
      mismatch <= cmp_miss;

      if (cmp_en && chk_count != {CHK_W{1'b1}}) begin
        chk_count <= chk_count + 1'b1;
      end

      // clr_err beats a simultaneous mismatch for both the counter and the FSM.
      if (clr_err) begin
        err_count <= '0;
      end else if (cmp_miss && err_count != {ERR_W{1'b1}}) begin
        err_count <= err_count + 1'b1;
      end

      case (st)
        ST_UNKNOWN: begin
          if (cmp_en) begin
            st <= (cmp_miss && !clr_err) ? ST_FAIL : ST_TRACK;
          end
        end
        ST_TRACK: begin
          if (cmp_miss && !clr_err) begin
            st <= ST_FAIL;
          end
        end
        ST_FAIL: begin
          if (clr_err) begin
            st <= ST_TRACK;
          end
        end
        default: st <= ST_UNKNOWN;
      endcase
    end
  end

  assign state = st;

`ifdef JK_OP_COV_EN
  logic [4:0]       cov_hit;
  logic [CHK_W-1:0] cov_cnt [5];

  // Index order: hold, set, clr, tog, rst. Only enabled, non-reset cycles count as JK ops.
  assign cov_hit = {mon_rst,
                    op_en && (op == OP_TOG),
                    op_en && (op == OP_CLR),
                    op_en && (op == OP_SET),
                    op_en && (op == OP_HOLD)};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        cov_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (cov_hit[i] && cov_cnt[i] != {CHK_W{1'b1}}) begin
          cov_cnt[i] <= cov_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cov_hold = cov_cnt[0];
  assign cov_set  = cov_cnt[1];
  assign cov_clr  = cov_cnt[2];
  assign cov_tog  = cov_cnt[3];
  assign cov_rst  = cov_cnt[4];
`endif

endmodule

// File: tb/tb_jk_ff_checker.sv
// Directed bench for jk_ff_checker; three instances cover default, LATENCY=2 and tiny saturating counters.
// Coverage counter checks compile in when JK_OP_COV_EN is defined.
module tb_jk_ff_checker;
  import jk_mon_pkg::*;

  logic clk = 1'b0;
  logic rst, mon_j, mon_k, mon_en, mon_rst, mon_q, clr_err;

  logic        m_mis;
  logic [7:0]  m_err;
  logic [15:0] m_chk;
  logic [1:0]  m_state;

  logic        l_mis;
  logic [7:0]  l_err;
  logic [15:0] l_chk;
  logic [1:0]  l_state;

  logic        s_mis;
  logic [1:0]  s_err;
  logic [1:0]  s_chk;
  logic [1:0]  s_state;

`ifdef JK_OP_COV_EN
  logic [15:0] m_cov [5];
  logic [15:0] l_cov [5];
  logic [1:0]  s_cov [5];
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  jk_ff_checker u_dut (
    .clk(clk), .rst(rst), .mon_j(mon_j), .mon_k(mon_k), .mon_en(mon_en),
    .mon_rst(mon_rst), .mon_q(mon_q), .clr_err(clr_err),
    .mismatch(m_mis), .err_count(m_err), .chk_count(m_chk), .state(m_state)
`ifdef JK_OP_COV_EN
    , .cov_hold(m_cov[0]), .cov_set(m_cov[1]), .cov_clr(m_cov[2]),
    .cov_tog(m_cov[3]), .cov_rst(m_cov[4])
`endif
  );

  jk_ff_checker #(.LATENCY(2)) u_lat2 (
    .clk(clk), .rst(rst), .mon_j(mon_j), .mon_k(mon_k), .mon_en(mon_en),
    .mon_rst(mon_rst), .mon_q(mon_q), .clr_err(clr_err),
    .mismatch(l_mis), .err_count(l_err), .chk_count(l_chk), .state(l_state)
`ifdef JK_OP_COV_EN
    , .cov_hold(l_cov[0]), .cov_set(l_cov[1]), .cov_clr(l_cov[2]),
    .cov_tog(l_cov[3]), .cov_rst(l_cov[4])
`endif
  );

  jk_ff_checker #(.ERR_W(2), .CHK_W(2)) u_sat (
    .clk(clk), .rst(rst), .mon_j(mon_j), .mon_k(mon_k), .mon_en(mon_en),
    .mon_rst(mon_rst), .mon_q(mon_q), .clr_err(clr_err),
    .mismatch(s_mis), .err_count(s_err), .chk_count(s_chk), .state(s_state)
`ifdef JK_OP_COV_EN
    , .cov_hold(s_cov[0]), .cov_set(s_cov[1]), .cov_clr(s_cov[2]),
    .cov_tog(s_cov[3]), .cov_rst(s_cov[4])
`endif
  );

  // Packed view {mismatch, state, err_count, chk_count} of the default instance.
  function automatic logic [26:0] mk(input logic m, input logic [1:0] st,
                                     input logic [7:0] e, input logic [15:0] c);
    return {m, st, e, c};
  endfunction

  function automatic logic [26:0] snap();
    return {m_mis, m_state, m_err, m_chk};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic j, input logic k,
                       input logic r, input logic q, input logic c);
    mon_en  = en;
    mon_j   = j;
    mon_k   = k;
    mon_rst = r;
    mon_q   = q;
    clr_err = c;
    tick();
  endtask

  task automatic do_rst();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    n_cmp++;
    if (snap() !== mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0)) begin
      n_bad++;
      $display("FAIL reset_dut observed=%h expected=%h", snap(), mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0));
    end
    n_cmp++;
    if ({s_mis, s_state, s_err, s_chk, l_mis, l_state, l_err, l_chk} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_variants observed=%h expected=0",
               {s_mis, s_state, s_err, s_chk, l_mis, l_state, l_err, l_chk});
    end
    rst = 1'b0;
  endtask

  task automatic test_mon_rst();
    // Reset beats an enabled toggle; expected Q is 0.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (snap() !== mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0)) begin
      n_bad++;
      $display("FAIL monrst_pre observed=%h expected=%h", snap(), mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (snap() !== mk(1'b0, ST_TRACK, 8'd0, 16'd1)) begin
      n_bad++;
      $display("FAIL monrst_track observed=%h expected=%h", snap(), mk(1'b0, ST_TRACK, 8'd0, 16'd1));
    end
    n_cmp++;
    if ({l_state, l_chk} !== {ST_UNKNOWN, 16'd0}) begin
      n_bad++;
      $display("FAIL lat2_wait observed=%h expected=%h", {l_state, l_chk}, {ST_UNKNOWN, 16'd0});
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({l_state, l_chk, m_chk} !== {ST_TRACK, 16'd1, 16'd2}) begin
      n_bad++;
      $display("FAIL lat2_track observed=%h expected=%h", {l_state, l_chk, m_chk}, {ST_TRACK, 16'd1, 16'd2});
    end
  endtask

  task automatic test_sequence();
    logic [4:0]  stim [5];
    logic [26:0] exp  [5];
    // {en, j, k, mon_q, clr_err}; mon_q carries the previous step's result.
    stim = '{5'b11000, 5'b10110, 5'b10000, 5'b11100, 5'b00010};
    exp  = '{mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0), mk(1'b0, ST_TRACK, 8'd0, 16'd1),
             mk(1'b0, ST_TRACK, 8'd0, 16'd2), mk(1'b0, ST_TRACK, 8'd0, 16'd3),
             mk(1'b0, ST_TRACK, 8'd0, 16'd4)};
    do_rst();
    for (int i = 0; i < 5; i++) begin
      drive(stim[i][4], stim[i][3], stim[i][2], 1'b0, stim[i][1], stim[i][0]);
      n_cmp++;
      if (snap() !== exp[i]) begin
        n_bad++;
        $display("FAIL seq_step%0d observed=%h expected=%h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic test_mismatch();
    logic [4:0]  stim [6];
    logic [26:0] exp  [6];
    stim = '{5'b11000, 5'b10100, 5'b10000, 5'b11100, 5'b00010, 5'b00000};
    exp  = '{mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0), mk(1'b1, ST_FAIL, 8'd1, 16'd1),
             mk(1'b0, ST_FAIL, 8'd1, 16'd2), mk(1'b0, ST_FAIL, 8'd1, 16'd3),
             mk(1'b0, ST_FAIL, 8'd1, 16'd4), mk(1'b1, ST_FAIL, 8'd2, 16'd5)};
    do_rst();
    for (int i = 0; i < 6; i++) begin
      drive(stim[i][4], stim[i][3], stim[i][2], 1'b0, stim[i][1], stim[i][0]);
      n_cmp++;
      if (snap() !== exp[i]) begin
        n_bad++;
        $display("FAIL miss_step%0d observed=%h expected=%h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic test_clr_collide();
    logic [1:0]  stim [4];
    logic [26:0] exp  [4];
    // {mon_q, clr_err} with the model holding q=1.
    stim = '{2'b01, 2'b10, 2'b00, 2'b11};
    exp  = '{mk(1'b1, ST_TRACK, 8'd0, 16'd6), mk(1'b0, ST_TRACK, 8'd0, 16'd7),
             mk(1'b1, ST_FAIL, 8'd1, 16'd8), mk(1'b0, ST_TRACK, 8'd0, 16'd9)};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, stim[i][1], stim[i][0]);
      n_cmp++;
      if (snap() !== exp[i]) begin
        n_bad++;
        $display("FAIL clr_step%0d observed=%h expected=%h", i, snap(), exp[i]);
      end
    end
  endtask

  task automatic test_rst_mid();
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_cmp++;
    if (snap() !== mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0)) begin
      n_bad++;
      $display("FAIL rstmid_outputs observed=%h expected=%h", snap(), mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0));
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if (snap() !== mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0)) begin
      n_bad++;
      $display("FAIL rstmid_history observed=%h expected=%h", snap(), mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0));
    end
  endtask

  task automatic test_toggle_unknown();
    do_rst();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (snap() !== mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0)) begin
        n_bad++;
        $display("FAIL tog_unknown%0d observed=%h expected=%h", i, snap(), mk(1'b0, ST_UNKNOWN, 8'd0, 16'd0));
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_err;
    do_rst();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      exp_err = (i >= 2) ? 2'd3 : 2'(i + 1);
      n_cmp++;
      if (s_err !== exp_err) begin
        n_bad++;
        $display("FAIL sat_err%0d observed=%0d expected=%0d", i, s_err, exp_err);
      end
    end
    n_cmp++;
    if ({s_mis, s_state, s_chk} !== {1'b1, ST_FAIL, 2'd3}) begin
      n_bad++;
      $display("FAIL sat_chk observed=%h expected=%h", {s_mis, s_state, s_chk}, {1'b1, ST_FAIL, 2'd3});
    end
    n_cmp++;
    if (snap() !== mk(1'b1, ST_FAIL, 8'd5, 16'd5)) begin
      n_bad++;
      $display("FAIL sat_wide observed=%h expected=%h", snap(), mk(1'b1, ST_FAIL, 8'd5, 16'd5));
    end
  endtask

`ifdef JK_OP_COV_EN
  task automatic test_cov();
    logic [15:0] exp_cov [5];
    exp_cov = '{16'd1, 16'd2, 16'd1, 16'd3, 16'd2};
    do_rst();
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (m_cov[i] !== exp_cov[i]) begin
        n_bad++;
        $display("FAIL cov_idx%0d observed=%0d expected=%0d", i, m_cov[i], exp_cov[i]);
      end
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not complete");
  end

  initial begin
    test_reset();
    test_mon_rst();
    test_sequence();
    test_mismatch();
    test_clr_collide();
    test_rst_mid();
    test_toggle_unknown();
    test_saturate();
`ifdef JK_OP_COV_EN
    test_cov();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
